ram_loader: RTL and testbench

- Program/data loader on the responder side of the CPU's `en_ram_in` request.
- `top_cpu` raises `en_ram_in` to request RAM initialisation. This block then accepts words from an upstream source over a valid/ready handshake and writes them to consecutive RAM addresses.
- It signals completion to the CPU with a one-cycle `load_done` pulse.
- It sits between the external source (bench model or UART deframer) and the CPU instruction/data RAM write port.

---
 rtl/ram_loader.sv | 133 +++++++++++++
 tb/tb_ram_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader -- responder to the CPU's RAM-initialisation request.
//
// While en_ram_in is held high, words arriving on a valid/ready handshake
// are written to consecutive RAM addresses starting at BASE_ADDR. After
// LOAD_LEN words, load_done pulses for one cycle. The block then waits for
// en_ram_in to fall before it can be re-armed. Dropping en_ram_in mid-load
// aborts the load without a load_done pulse.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   defined   -> checksum accumulates the sum (mod 2^DATA_W) of accepted words
//   undefined -> no adder is built and checksum is tied to 0
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en_ram_in  load request level from top_cpu
//   src_data   upstream word
//   src_valid  upstream word valid
//   src_ready  loader accepts a word this cycle (high only in LOAD)
//   ram_we     RAM write strobe (registered)
//   ram_addr   RAM write address (registered)
//   ram_wdata  RAM write data (registered)
//   load_busy  high while in LOAD
//   load_done  one-cycle pulse on load completion (registered)
//   word_count words accepted in the current or most recent load
//   checksum   running sum of accepted words (see macro above)

module ram_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int LOAD_LEN  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_ram_in,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);
  // word_count value just before the final acceptance of a load
  localparam logic [ADDR_W:0]   LAST_C = (ADDR_W+1)'(LOAD_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              start;

  // Ready depends on state only, so the source never sees a combinational
  // path from its own valid back to ready.
  assign src_ready = (state == LOAD);
  assign load_busy = (state == LOAD);
  assign accept    = (state == LOAD) && src_valid;
  assign start     = (state == IDLE) && en_ram_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= BASE_C;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      load_done  <= 1'b0;
      word_count <= '0;
    end else begin
      ram_we    <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en_ram_in) begin
            state      <= LOAD;
            ptr        <= BASE_C;
            word_count <= '0;
          end
        end
        LOAD: begin
          if (src_valid) begin
            ram_we     <= 1'b1;
            ram_addr   <= ptr;
            ram_wdata  <= src_data;
            ptr        <= ptr + 1'b1;
            word_count <= word_count + 1'b1;
          end
          // Completion wins over a simultaneous abort: the last word was
          // accepted, so the load did finish.
          if (src_valid && (word_count == LAST_C)) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else if (!en_ram_in) begin
            state <= IDLE;
          end
        end
        DONE: state <= HOLD;
        HOLD: begin
          // Wait for the request to drop so a held request cannot re-trigger.
          if (!en_ram_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (start) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + src_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

  logic clk;
  logic rst;

  // Instance A: 256-word address space, BASE_ADDR=0x10, LOAD_LEN=4
  logic        en_a, valid_a, ready_a, we_a, busy_a, done_a;
  logic [15:0] data_a, wdata_a, cs_a;
  logic [7:0]  addr_a;
  logic [8:0]  wc_a;

  // Instance B: ADDR_W=2, BASE_ADDR=3, LOAD_LEN=3 (wrap test)
  logic        en_b, valid_b, ready_b, we_b, busy_b, done_b;
  logic [15:0] data_b, wdata_b, cs_b;
  logic [1:0]  addr_b;
  logic [2:0]  wc_b;

  int total;
  int bad;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CS_ON = 1'b1;
`else
  localparam bit CS_ON = 1'b0;
`endif

  ram_loader #(.DATA_W(16), .ADDR_W(8), .BASE_ADDR(16), .LOAD_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .en_ram_in(en_a), .src_data(data_a),
    .src_valid(valid_a), .src_ready(ready_a), .ram_we(we_a),
    .ram_addr(addr_a), .ram_wdata(wdata_a), .load_busy(busy_a),
    .load_done(done_a), .word_count(wc_a), .checksum(cs_a)
  );

  ram_loader #(.DATA_W(16), .ADDR_W(2), .BASE_ADDR(3), .LOAD_LEN(3)) dut_b (
    .clk(clk), .rst(rst), .en_ram_in(en_b), .src_data(data_b),
    .src_valid(valid_b), .src_ready(ready_b), .ram_we(we_b),
    .ram_addr(addr_b), .ram_wdata(wdata_b), .load_busy(busy_b),
    .load_done(done_b), .word_count(wc_b), .checksum(cs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cs(input logic [31:0] v);
    return CS_ON ? v : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic pat [7];
  int   k;

  initial begin
    total = 0; bad = 0;
    rst = 1'b0;
    en_a = 0; valid_a = 0; data_a = '0;
    en_b = 0; valid_b = 0; data_b = '0;
    tick(); tick();

    // ---- reset state ----
    chk("rst_we",    we_a, 0);
    chk("rst_addr",  addr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    chk("rst_done",  done_a, 0);
    chk("rst_wc",    wc_a, 0);
    chk("rst_cs",    cs_a, 0);
    chk("rst_ready", ready_a, 0);
    chk("rst_busy",  busy_a, 0);
    rst = 1'b1;
    tick();

    // ---- reset mid-stream ----
    en_a = 1;
    tick();
    chk("mid_ready", ready_a, 1);
    valid_a = 1; data_a = 16'hAAAA;
    tick();
    chk("mid_we0",   we_a, 1);
    chk("mid_addr0", addr_a, 8'h10);
    data_a = 16'hBBBB;
    tick();
    chk("mid_addr1", addr_a, 8'h11);
    chk("mid_wc1",   wc_a, 2);
    data_a = 16'hCCCC;
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_we",    we_a, 0);
    chk("mid_rst_addr",  addr_a, 0);
    chk("mid_rst_wdata", wdata_a, 0);
    chk("mid_rst_wc",    wc_a, 0);
    chk("mid_rst_cs",    cs_a, 0);
    chk("mid_rst_busy",  busy_a, 0);
    chk("mid_rst_ready", ready_a, 0);
    tick();
    chk("mid_rst_we2",   we_a, 0);
    en_a = 0; valid_a = 0;
    rst = 1'b1;
    tick();

    // ---- basic back-to-back load ----
    en_a = 1; valid_a = 1; data_a = 16'h1111;  // valid in IDLE is ignored
    tick();
    chk("basic_idle_we", we_a, 0);
    chk("basic_wc0",     wc_a, 0);
    chk("basic_ready",   ready_a, 1);
    tick();
    chk("basic_we0",   we_a, 1);
    chk("basic_addr0", addr_a, 8'h10);
    chk("basic_data0", wdata_a, 16'h1111);
    chk("basic_done0", done_a, 0);
    data_a = 16'h2222;
    tick();
    chk("basic_addr1", addr_a, 8'h11);
    chk("basic_data1", wdata_a, 16'h2222);
    data_a = 16'h3333;
    tick();
    chk("basic_addr2", addr_a, 8'h12);
    chk("basic_data2", wdata_a, 16'h3333);
    chk("basic_done2", done_a, 0);
    data_a = 16'h4444;
    tick();
    chk("basic_we3",   we_a, 1);
    chk("basic_addr3", addr_a, 8'h13);
    chk("basic_data3", wdata_a, 16'h4444);
    chk("basic_done3", done_a, 1);
    chk("basic_wc4",   wc_a, 4);
    chk("basic_rdy_done", ready_a, 0);
    chk("basic_cs",    cs_a, exp_cs(32'hAAAA));
    data_a = 16'h5555;  // held valid must be ignored in HOLD
    tick();
    chk("hold_we",    we_a, 0);
    chk("hold_done",  done_a, 0);
    chk("hold_wc",    wc_a, 4);
    chk("hold_cs",    cs_a, exp_cs(32'hAAAA));
    tick();
    chk("hold_we2",    we_a, 0);
    chk("hold_ready2", ready_a, 0);
    en_a = 0; valid_a = 0;
    tick();
    chk("idle_busy", busy_a, 0);
    chk("idle_wc_kept", wc_a, 4);

    // ---- throttled source ----
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    en_a = 1;
    tick();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      valid_a = pat[i];
      data_a  = 16'h0100 + 16'(i);
      tick();
      chk($sformatf("thr_we%0d", i), we_a, pat[i]);
      chk($sformatf("thr_done%0d", i), done_a, (i == 6) ? 1 : 0);
      if (pat[i]) begin
        chk($sformatf("thr_addr%0d", i), addr_a, 32'h10 + k);
        chk($sformatf("thr_data%0d", i), wdata_a, 32'h0100 + i);
        k++;
      end
    end
    chk("thr_wc", wc_a, 4);
    chk("thr_cs", cs_a, exp_cs(32'h040D));
    valid_a = 0;
    tick();
    en_a = 0;
    tick();

    // ---- abort (drop coincides with second acceptance) ----
    en_a = 1;
    tick();
    valid_a = 1; data_a = 16'h0A01;
    tick();
    chk("abt_addr0", addr_a, 8'h10);
    data_a = 16'h0A02; en_a = 0;
    tick();
    chk("abt_we1",   we_a, 1);
    chk("abt_addr1", addr_a, 8'h11);
    chk("abt_data1", wdata_a, 16'h0A02);
    chk("abt_done",  done_a, 0);
    chk("abt_busy",  busy_a, 0);
    chk("abt_wc",    wc_a, 2);
    chk("abt_cs",    cs_a, exp_cs(32'h1403));
    valid_a = 0;
    tick();
    chk("abt_we_off", we_a, 0);
    chk("abt_done2",  done_a, 0);
    chk("abt_wc_kept", wc_a, 2);
    en_a = 1;
    tick();
    chk("rst_wc_restart", wc_a, 0);
    chk("rst_cs_restart", cs_a, 0);
    chk("restart_ready",  ready_a, 1);
    valid_a = 1; data_a = 16'h0B00;
    tick();
    chk("restart_addr", addr_a, 8'h10);
    chk("restart_wc",   wc_a, 1);
    en_a = 0; valid_a = 0;
    tick();
    chk("restart_abort_we", we_a, 0);
    chk("restart_abort_busy", busy_a, 0);

    // ---- wrap and hold on instance B ----
    en_b = 1;
    tick();
    valid_b = 1; data_b = 16'h00C0;
    tick();
    chk("wrap_addr0", addr_b, 3);
    chk("wrap_data0", wdata_b, 16'h00C0);
    data_b = 16'h00C1;
    tick();
    chk("wrap_addr1", addr_b, 0);
    chk("wrap_done1", done_b, 0);
    data_b = 16'h00C2;
    tick();
    chk("wrap_addr2", addr_b, 1);
    chk("wrap_data2", wdata_b, 16'h00C2);
    chk("wrap_done2", done_b, 1);
    chk("wrap_wc",    wc_b, 3);
    chk("wrap_cs",    cs_b, exp_cs(32'h0243));
    tick();
    chk("whold_we0",   we_b, 0);
    chk("whold_done0", done_b, 0);
    tick();
    chk("whold_we1",    we_b, 0);
    chk("whold_ready1", ready_b, 0);
    tick();
    chk("whold_we2", we_b, 0);
    chk("whold_wc",  wc_b, 3);
    en_b = 0;
    tick();
    chk("wrel_we",   we_b, 0);
    chk("wrel_busy", busy_b, 0);
    en_b = 1; data_b = 16'h00D0;
    tick();
    chk("wre_we",    we_b, 0);
    chk("wre_wc",    wc_b, 0);
    chk("wre_ready", ready_b, 1);
    tick();
    chk("wre_addr",  addr_b, 3);
    chk("wre_data",  wdata_b, 16'h00D0);
    chk("wre_wc1",   wc_b, 1);
    en_b = 0; valid_b = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
